// File: rtl/spi_4094_driver.sv
// spi_4094_driver: serialises reg_4094 MSB-first into a daisy-chained 4094 shift register chain.
// Optional macro SPI_4094_DRIVER_READBACK_EN adds chain_qs/readback capture of the previous chain contents.
module spi_4094_driver #(
    parameter int WIDTH   = 24,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] reg_4094,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             out_clk,
    output logic             out_data,
    output logic             out_strobe,
    output logic             out_oe
`ifdef SPI_4094_DRIVER_READBACK_EN
    ,
    input  logic             chain_qs,
    output logic [WIDTH-1:0] readback
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CLK_LO, CLK_HI, STROBE, FINISH} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_shift, r_last;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_div;
    logic             r_force, r_pend, r_oe;
    logic             w_begin, w_div_end;

    assign w_div_end = r_div == 8'(CLK_DIV - 1);
    assign w_begin   = r_state == IDLE && (start || r_pend || r_force || reg_4094 != r_last);

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        w_next     = r_state;
        busy       = r_state == CLK_LO || r_state == CLK_HI || r_state == STROBE;
        done       = r_state == FINISH;
        out_clk    = r_state == CLK_HI;
        out_data   = (r_state == CLK_LO || r_state == CLK_HI) && r_shift[WIDTH-1];
        out_strobe = r_state == STROBE;
        out_oe     = r_oe;
        case (r_state)
            IDLE:    w_next = w_begin ? CLK_LO : IDLE;
            CLK_LO:  w_next = w_div_end ? CLK_HI : CLK_LO;
            CLK_HI:  w_next = w_div_end ? (r_cnt == CW'(1) ? STROBE : CLK_LO) : CLK_HI;
            STROBE:  w_next = w_div_end ? FINISH : STROBE;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_last  <= '0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_force <= 1'b1;
            r_pend  <= 1'b0;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_div   <= (r_state == IDLE || r_state == FINISH || w_div_end) ? 8'd0 : r_div + 8'd1;
            if (start && r_state != IDLE)
                r_pend <= 1'b1;
            if (w_begin) begin
                r_shift <= reg_4094;
                r_last  <= reg_4094;
                r_force <= 1'b0;
                r_pend  <= 1'b0;
                r_cnt   <= CW'(WIDTH);
            end
            if (r_state == CLK_HI && w_div_end) begin
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt - CW'(1);
            end
            if (r_state == FINISH)
                r_oe <= 1'b1;
        end
    end

`ifdef SPI_4094_DRIVER_READBACK_EN
    logic [WIDTH-1:0] r_rb, r_readback;

    assign readback = r_readback;

    // QS' is sampled as out_clk rises, before the chain shifts, so the first sample is the old MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb       <= '0;
            r_readback <= '0;
        end else begin
            if (r_state == CLK_LO && w_div_end)
                r_rb <= {r_rb[WIDTH-2:0], chain_qs};
            if (r_state == FINISH)
                r_readback <= r_rb;
        end
    end
`endif
endmodule

// File: tb/tb_spi_4094_driver.sv
// tb_spi_4094_driver: directed scoreboard bench; expected words queued at stimulus, popped at each done.
module tb_spi_4094_driver;
    typedef struct packed {
        logic [23:0] d;
        logic        oe;
    } exp_t;
    typedef struct packed {
        logic [23:0] d;
        logic [7:0]  bits;
        logic [15:0] bcyc;
        logic [7:0]  str;
        logic        oe;
    } got_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [23:0] reg_4094;
    logic        busy, done, out_clk, out_data, out_strobe, out_oe;
    int          errors = 0, checks = 0;
    exp_t        q_exp[$];
    got_t        q_got[$];
    logic [23:0] m_d = '0;
    int          m_bits = 0, m_bcyc = 0, m_str = 0, m_viol = 0;
    logic        p_clk = 1'b0, p_data = 1'b0, p_str = 1'b0;
`ifdef SPI_4094_DRIVER_READBACK_EN
    logic [23:0] chain, readback;
    always @(posedge out_clk) chain <= {chain[22:0], out_data};
`endif

    always #5 clk = ~clk;

    spi_4094_driver dut (
        .clk(clk), .rst(rst), .reg_4094(reg_4094), .start(start),
        .busy(busy), .done(done), .out_clk(out_clk), .out_data(out_data),
        .out_strobe(out_strobe), .out_oe(out_oe)
`ifdef SPI_4094_DRIVER_READBACK_EN
        , .chain_qs(chain[23]), .readback(readback)
`endif
    );

    always @(negedge clk) begin
        if (rst) begin
            m_d = '0; m_bits = 0; m_bcyc = 0; m_str = 0;
        end else begin
            if (out_clk && !p_clk) begin
                m_d = {m_d[22:0], out_data};
                m_bits++;
            end
            if (out_clk && p_clk && out_data !== p_data) m_viol++;
            if (busy) m_bcyc++;
            if (out_strobe && !p_str) m_str++;
            if (done) begin
                q_got.push_back({m_d, 8'(m_bits), 16'(m_bcyc), 8'(m_str), out_oe});
                m_d = '0; m_bits = 0; m_bcyc = 0; m_str = 0;
            end
        end
        p_clk = out_clk; p_data = out_data; p_str = out_strobe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_got(input int n);
        for (int k = 0; k < 4000 && q_got.size() < n; k++) @(negedge clk);
        chk("wait_done", 32'(q_got.size() >= n), 32'd1);
    endtask

    task automatic check_xfer(input string tag);
        exp_t e;
        got_t g;
        if (q_got.size() == 0 || q_exp.size() == 0) return;
        e = q_exp.pop_front();
        g = q_got.pop_front();
        chk({tag, "_data"}, 32'(g.d), 32'(e.d));
        chk({tag, "_bits"}, 32'(g.bits), 32'd24);
        chk({tag, "_busy_cycles"}, 32'(g.bcyc), 32'd196);
        chk({tag, "_strobes"}, 32'(g.str), 32'd1);
        chk({tag, "_oe_at_done"}, 32'(g.oe), 32'(e.oe));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; reg_4094 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_clk", 32'(out_clk), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_strobe", 32'(out_strobe), 0);
        chk("rst_oe", 32'(out_oe), 0);
        q_exp.push_back({24'h0, 1'b0});
        rst = 1'b0;
        wait_got(1);
        check_xfer("auto");
        @(negedge clk);
        chk("oe_after_auto", 32'(out_oe), 1);

        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        reg_4094 = 24'hA5C3F0;
        q_exp.push_back({24'hA5C3F0, 1'b1});
        wait_got(1);
        check_xfer("a5c3f0");

        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_start", 32'(busy), 1);
        q_exp.push_back({24'hA5C3F0, 1'b1});
        q_exp.push_back({24'hA5C3F0, 1'b1});
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (15) @(negedge clk);
        end
        wait_got(2);
        check_xfer("start1");
        check_xfer("pending");
        repeat (600) @(negedge clk);
        chk("no_extra_xfer", 32'(q_got.size()), 0);
        chk("idle_after_merge", 32'(busy), 0);

        reg_4094 = 24'h00FF00;
        for (int k = 0; k < 2000 && m_bits < 10; k++) @(negedge clk);
        chk("reached_bit10", 32'(m_bits), 10);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_clk", 32'(out_clk), 0);
        chk("abort_data", 32'(out_data), 0);
        chk("abort_strobe", 32'(out_strobe), 0);
        chk("abort_oe", 32'(out_oe), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_strobe", 32'(out_strobe), 0);
        chk("abort_no_done", 32'(q_got.size()), 0);
        q_exp.push_back({24'h00FF00, 1'b0});
        rst = 1'b0;
        @(negedge clk);
        chk("oe_low_during_resend", 32'(out_oe), 0);
        wait_got(1);
        check_xfer("resend");
        @(negedge clk);
        chk("oe_after_resend", 32'(out_oe), 1);

`ifdef SPI_4094_DRIVER_READBACK_EN
        repeat (5) @(negedge clk);
        chain = 24'h123456;
        reg_4094 = 24'h3C3C3C;
        q_exp.push_back({24'h3C3C3C, 1'b1});
        wait_got(1);
        check_xfer("readback_xfer");
        @(negedge clk);
        chk("readback", 32'(readback), 32'h123456);
        chk("chain_contents", 32'(chain), 32'h3C3C3C);
`endif

        chk("data_stable_while_clk_high", 32'(m_viol), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
